// File: rtl/bastim_cap_ch.sv
// bastim_cap_ch - input-capture channel for the basic timer.
// Synchronizes and glitch-filters an external input, measures the number of
// prescaled ticks between consecutive selected edges and presents each
// measurement through a capture register with a pending/ack handshake.
//
// Ports:
//   ch_clk, ch_rstn            clock, async active-low reset
//   ch_cap_enable              channel enable (level)
//   ch_cap_in                  external asynchronous input
//   ch_cap_ack                 one-cycle pulse, consumes the pending capture
//   r_psc                      prescaler (0 behaves as 1)
//   r_edge_sel                 00 rising, 01 falling, 1x both
//   r_filter                   filter depth (r_filter+1 equal samples)
//   cap_value                  last captured tick count
//   cap_pending                capture not yet acknowledged
//   int_status_ch_capture      pulse per capture
//   int_status_ch_overflow     pulse on counter saturation
//   int_status_ch_overcapture  pulse when a pending capture is overwritten
//
// state  | meaning
// S_IDLE | channel disabled, counters cleared
// S_ARM  | waiting for the first selected edge; no capture on it
// S_MEAS | counting ticks; each selected edge captures and restarts
module bastim_cap_ch #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             ch_clk,
    input  logic             ch_rstn,
    input  logic             ch_cap_enable,
    input  logic             ch_cap_in,
    input  logic             ch_cap_ack,
    input  logic [15:0]      r_psc,
    input  logic [1:0]       r_edge_sel,
    input  logic [3:0]       r_filter,
    output logic [CNT_W-1:0] cap_value,
    output logic             cap_pending,
    output logic             int_status_ch_capture,
    output logic             int_status_ch_overflow,
    output logic             int_status_ch_overcapture
);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEAS} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_in;
    logic                   flt, flt_d;
    logic [3:0]             flt_cnt;
    logic                   rise, fall, edge_evt;
    logic [15:0]            psc_cnt, psc_eff;
    logic                   tick;
    logic [CNT_W-1:0]       cnt, cap_next;
    logic                   cnt_max;
    logic                   do_cap, do_ovf, clr_cnt, run_cnt;

    assign sync_in = sync_q[SYNC_STAGES-1];

    // Synchronizer and filter run regardless of enable so that enabling
    // never sees a stale level and a false edge.
    always_ff @(posedge ch_clk or negedge ch_rstn) begin
        if (!ch_rstn) begin
            sync_q  <= '0;
            flt     <= 1'b0;
            flt_d   <= 1'b0;
            flt_cnt <= 4'd0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ch_cap_in};
            flt_d  <= flt;
            if (sync_in == flt) begin
                flt_cnt <= 4'd0;
            end else if (flt_cnt >= r_filter) begin
                // >= keeps the filter sane if r_filter shrinks mid-count
                flt     <= sync_in;
                flt_cnt <= 4'd0;
            end else begin
                flt_cnt <= flt_cnt + 4'd1;
            end
        end
    end

    assign rise     = flt & ~flt_d;
    assign fall     = ~flt & flt_d;
    assign edge_evt = r_edge_sel[1] ? (rise | fall) :
                      r_edge_sel[0] ? fall : rise;

    assign psc_eff  = (r_psc == 16'd0) ? 16'd1 : r_psc;
    assign tick     = (state_q == S_MEAS) && (psc_cnt >= psc_eff - 16'd1);
    assign cnt_max  = &cnt;
    // Edge coincident with a tick includes the tick; saturates at all-ones.
    assign cap_next = (tick && !cnt_max) ? cnt + CNT_W'(1) : cnt;

    always_comb begin
        state_d = state_q;
        do_cap  = 1'b0;
        do_ovf  = 1'b0;
        clr_cnt = 1'b0;
        run_cnt = 1'b0;
        if (!ch_cap_enable) begin
            state_d = S_IDLE;
            clr_cnt = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_ARM;
                S_ARM: begin
                    if (edge_evt) begin
                        state_d = S_MEAS;
                        clr_cnt = 1'b1;
                    end
                end
                S_MEAS: begin
                    if (edge_evt) begin
                        do_cap  = 1'b1;
                        clr_cnt = 1'b1;
                    end else if (tick && cnt_max) begin
                        do_ovf  = 1'b1;
                        clr_cnt = 1'b1;
                        state_d = S_ARM;
                    end else begin
                        run_cnt = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge ch_clk or negedge ch_rstn) begin
        if (!ch_rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge ch_clk or negedge ch_rstn) begin
        if (!ch_rstn) begin
            psc_cnt <= 16'd0;
            cnt     <= '0;
        end else if (clr_cnt) begin
            psc_cnt <= 16'd0;
            cnt     <= '0;
        end else if (run_cnt) begin
            psc_cnt <= tick ? 16'd0 : psc_cnt + 16'd1;
            if (tick) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge ch_clk or negedge ch_rstn) begin
        if (!ch_rstn) begin
            cap_value                 <= '0;
            cap_pending               <= 1'b0;
            int_status_ch_capture     <= 1'b0;
            int_status_ch_overflow    <= 1'b0;
            int_status_ch_overcapture <= 1'b0;
        end else begin
            if (do_cap) begin
                cap_value <= cap_next;
            end
            if (do_cap) begin
                cap_pending <= 1'b1;
            end else if (ch_cap_ack) begin
                cap_pending <= 1'b0;
            end
            int_status_ch_capture     <= do_cap;
            int_status_ch_overflow    <= do_ovf;
            // A same-cycle ack consumes the old value, so no overcapture.
            int_status_ch_overcapture <= do_cap & cap_pending & ~ch_cap_ack;
        end
    end

endmodule

// File: tb/tb_bastim_cap_ch.sv
module tb_bastim_cap_ch;

    localparam int CNT_W = 8;

    logic             ch_clk = 1'b0;
    logic             ch_rstn;
    logic             ch_cap_enable;
    logic             ch_cap_in;
    logic             ch_cap_ack;
    logic [15:0]      r_psc;
    logic [1:0]       r_edge_sel;
    logic [3:0]       r_filter;
    logic [CNT_W-1:0] cap_value;
    logic             cap_pending;
    logic             int_status_ch_capture;
    logic             int_status_ch_overflow;
    logic             int_status_ch_overcapture;

    bastim_cap_ch #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
        .ch_clk                    (ch_clk),
        .ch_rstn                   (ch_rstn),
        .ch_cap_enable             (ch_cap_enable),
        .ch_cap_in                 (ch_cap_in),
        .ch_cap_ack                (ch_cap_ack),
        .r_psc                     (r_psc),
        .r_edge_sel                (r_edge_sel),
        .r_filter                  (r_filter),
        .cap_value                 (cap_value),
        .cap_pending               (cap_pending),
        .int_status_ch_capture     (int_status_ch_capture),
        .int_status_ch_overflow    (int_status_ch_overflow),
        .int_status_ch_overcapture (int_status_ch_overcapture)
    );

    always #5 ch_clk = ~ch_clk;

    typedef struct {
        int psc;
        int edge_sel;
        int filter;
        int high;
        int low;
        int periods;
        int n_cap;
        int exp_a;   // first and every other capture
        int exp_b;   // alternate captures in both-edge mode
    } vec_t;

    vec_t vecs[5];

    int n_checks = 0;
    int n_err    = 0;

    // Capture log, sampled 1 time unit after the active edge.
    int cap_q[$];
    int n_ovc = 0;
    int n_ovf = 0;

    always @(posedge ch_clk) begin
        #1;
        if (int_status_ch_capture)     cap_q.push_back(int'(cap_value));
        if (int_status_ch_overcapture) n_ovc++;
        if (int_status_ch_overflow)    n_ovf++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge ch_clk);
    endtask

    // which: 0 capture pulse, 1 overflow pulse. lat = negedges waited, -1 if none.
    task automatic wait_evt(input int which, input int max, output int lat);
        lat = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge ch_clk);
            if ((which == 0) ? int_status_ch_capture : int_status_ch_overflow) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic clean();
        ch_cap_enable = 1'b0;
        ch_cap_in     = 1'b0;
        ch_cap_ack    = 1'b1;
        tick(1);
        ch_cap_ack    = 1'b0;
        tick(12);
    endtask

    task automatic cfg_enable(input int psc, input int sel, input int flt);
        r_psc         = 16'(psc);
        r_edge_sel    = 2'(sel);
        r_filter      = 4'(flt);
        ch_cap_enable = 1'b1;
        tick(5);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int base, oc0, got_n;
        clean();
        chk($sformatf("v%0d_pending_cleared", idx), int'(cap_pending), 0);
        cfg_enable(v.psc, v.edge_sel, v.filter);
        base = cap_q.size();
        oc0  = n_ovc;
        for (int p = 0; p < v.periods; p++) begin
            ch_cap_in = 1'b1;
            tick(v.high);
            ch_cap_in = 1'b0;
            tick(v.low);
        end
        tick(10);
        got_n = cap_q.size() - base;
        chk($sformatf("v%0d_ncap", idx), got_n, v.n_cap);
        for (int i = 0; i < v.n_cap && i < got_n; i++) begin
            chk($sformatf("v%0d_cap%0d", idx, i), cap_q[base + i],
                (v.edge_sel >= 2 && (i % 2) == 1) ? v.exp_b : v.exp_a);
        end
        chk($sformatf("v%0d_overcap", idx), n_ovc - oc0, v.n_cap - 1);
        chk($sformatf("v%0d_pending", idx), int'(cap_pending), 1);
    endtask

    initial begin
        int lat, base, ovf0;

        //           psc sel flt high low per ncap a    b
        vecs[0] = '{1,   0,  0,  50,  50, 3,  2,   100, 100};
        vecs[1] = '{4,   2,  0,  40,  60, 2,  3,   10,  15};
        vecs[2] = '{0,   1,  0,  30,  45, 2,  1,   75,  75};
        vecs[3] = '{3,   0,  2,  20,  21, 3,  2,   13,  13};
        vecs[4] = '{5,   3,  1,  23,  17, 2,  3,   4,   3};

        ch_rstn       = 1'b0;
        ch_cap_enable = 1'b0;
        ch_cap_in     = 1'b0;
        ch_cap_ack    = 1'b0;
        r_psc         = 16'd1;
        r_edge_sel    = 2'd0;
        r_filter      = 4'd0;
        tick(2);
        chk("rst_cap_value", int'(cap_value), 0);
        chk("rst_pending", int'(cap_pending), 0);
        chk("rst_capture", int'(int_status_ch_capture), 0);
        chk("rst_overflow", int'(int_status_ch_overflow), 0);
        chk("rst_overcapture", int'(int_status_ch_overcapture), 0);
        ch_rstn = 1'b1;
        tick(3);

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // Glitch filter, depth 3, both edges.
        clean();
        cfg_enable(1, 2, 3);
        base = cap_q.size();
        repeat (3) begin
            ch_cap_in = 1'b1;
            tick(2);
            ch_cap_in = 1'b0;
            tick(10);
        end
        chk("glitch_no_capture", cap_q.size() - base, 0);
        ch_cap_in = 1'b1;
        tick(4);
        ch_cap_in = 1'b0;
        wait_evt(0, 30, lat);
        chk("filter3_latency", lat, 7);
        chk("filter3_value", int'(cap_value), 4);
        tick(5);
        chk("filter3_ncap", cap_q.size() - base, 1);

        // Latency reference with filter 0.
        clean();
        cfg_enable(1, 2, 0);
        ch_cap_in = 1'b1;
        tick(20);
        ch_cap_in = 1'b0;
        wait_evt(0, 30, lat);
        chk("filter0_latency", lat, 4);
        chk("filter0_value", int'(cap_value), 20);

        // Overflow: 256 ticks after the arming edge with an 8-bit counter.
        clean();
        cfg_enable(1, 0, 0);
        base = cap_q.size();
        ovf0 = n_ovf;
        ch_cap_in = 1'b1;
        wait_evt(1, 400, lat);
        chk("ovf_latency", lat, 260);
        chk("ovf_no_capture", cap_q.size() - base, 0);
        chk("ovf_cap_value_held", int'(cap_value), 20);
        tick(2);
        chk("ovf_count", n_ovf - ovf0, 1);
        ch_cap_in = 1'b0;
        tick(20);
        ch_cap_in = 1'b1;
        tick(50);
        ch_cap_in = 1'b0;
        tick(50);
        chk("ovf_rearm_no_capture", cap_q.size() - base, 0);
        ch_cap_in = 1'b1;
        tick(10);
        chk("ovf_next_ncap", cap_q.size() - base, 1);
        chk("ovf_next_value", int'(cap_value), 100);
        chk("ovf_single_pulse", n_ovf - ovf0, 1);
        ch_cap_in = 1'b0;

        // Ack coincident with a capture.
        clean();
        cfg_enable(1, 0, 0);
        ch_cap_in = 1'b1;
        tick(15);
        ch_cap_in = 1'b0;
        tick(15);
        ch_cap_in = 1'b1;
        tick(15);
        ch_cap_in = 1'b0;
        tick(25);
        chk("hs_pending_first", int'(cap_pending), 1);
        chk("hs_first_value", int'(cap_value), 30);
        ch_cap_in = 1'b1;
        tick(3);
        ch_cap_ack = 1'b1;
        tick(1);
        ch_cap_ack = 1'b0;
        chk("hs_coinc_capture", int'(int_status_ch_capture), 1);
        chk("hs_coinc_no_overcap", int'(int_status_ch_overcapture), 0);
        chk("hs_coinc_pending", int'(cap_pending), 1);
        chk("hs_coinc_value", int'(cap_value), 40);
        ch_cap_ack = 1'b1;
        tick(1);
        ch_cap_ack = 1'b0;
        chk("hs_ack_clears", int'(cap_pending), 0);
        ch_cap_ack = 1'b1;
        tick(1);
        ch_cap_ack = 1'b0;
        chk("hs_ack_idle", int'(cap_pending), 0);

        // Disable mid-measurement, re-enable, edge only re-arms.
        tick(6);
        ch_cap_in = 1'b0;
        tick(10);
        ch_cap_enable = 1'b0;
        tick(5);
        ch_cap_enable = 1'b1;
        tick(5);
        base = cap_q.size();
        ch_cap_in = 1'b1;
        tick(10);
        chk("dis_no_capture", cap_q.size() - base, 0);
        chk("dis_value_held", int'(cap_value), 40);
        tick(20);
        ch_cap_in = 1'b0;
        tick(30);
        ch_cap_in = 1'b1;
        tick(10);
        chk("dis_rearm_ncap", cap_q.size() - base, 1);
        chk("dis_rearm_value", int'(cap_value), 60);

        // Asynchronous reset while a capture pulse is high.
        tick(10);
        ch_cap_in = 1'b0;
        tick(20);
        ch_cap_in = 1'b1;
        wait_evt(0, 10, lat);
        chk("arst_pre_pulse", lat, 4);
        #1;
        ch_rstn = 1'b0;
        #1;
        chk("arst_cap_value", int'(cap_value), 0);
        chk("arst_pending", int'(cap_pending), 0);
        chk("arst_capture", int'(int_status_ch_capture), 0);
        chk("arst_overflow", int'(int_status_ch_overflow), 0);
        chk("arst_overcapture", int'(int_status_ch_overcapture), 0);
        tick(2);
        ch_rstn = 1'b1;
        tick(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
